// File: rtl/video_stream_rx_monitor_if.sv
// Video stream bundle carrying vsync / hsync / valid / data from a source stage
// to a receiver.
interface video_stream_if #(parameter int DATA_WIDTH = 8);
  logic                  vsync;
  logic                  hsync;
  logic                  valid;
  logic [DATA_WIDTH-1:0] dat;

  modport master (output vsync, hsync, valid, dat);
  modport slave  (input  vsync, hsync, valid, dat);
endinterface

// File: rtl/video_stream_rx_monitor.sv
// Receive-side monitor for the video stream: recovers pixel coordinates,
// measures resolution and flags timing errors. Optional checksum: VIDEO_RX_CHECKSUM_EN.
//
// state  | meaning
// IDLE   | after reset, waiting for the first vsync falling edge
// ACTIVE | inside a frame, counting pixels and lines
// SYNC   | vsync pulse between frames, results being latched
module video_stream_rx_monitor #(
  parameter int DATA_WIDTH = 8,
  parameter int H_DISP     = 800,
  parameter int V_DISP     = 600
) (
  input  logic                  clk,
  input  logic                  rst_n,
  video_stream_if.slave         vin,
  output logic                  pix_valid,
  output logic [DATA_WIDTH-1:0] pix_dat,
  output logic [15:0]           pix_x,
  output logic [15:0]           pix_y,
  output logic [15:0]           meas_xres,
  output logic [15:0]           meas_yres,
  output logic                  frame_done,
  output logic [15:0]           frame_cnt,
  output logic                  res_ok,
  output logic                  line_len_err,
  output logic                  sync_err,
  output logic [31:0]           frame_sum
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_SYNC} state_t;

  state_t                state_q, state_d;
  logic                  vs_q, vs_d, hs_q, hs_d, vld_q, vld_d;
  logic                  vs_p_q, vs_p_d, vld_p_q, vld_p_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic [15:0]           pix_cnt_q, pix_cnt_d, line_cnt_q, line_cnt_d;
  logic [15:0]           cur_xres_q, cur_xres_d;
  logic                  len_err_q, len_err_d, syn_err_q, syn_err_d;
  logic                  close_q, close_d;
  logic                  pix_valid_q, pix_valid_d;
  logic [DATA_WIDTH-1:0] pix_dat_q, pix_dat_d;
  logic [15:0]           pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [15:0]           meas_xres_q, meas_xres_d, meas_yres_q, meas_yres_d;
  logic                  frame_done_q, frame_done_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic                  res_ok_q, res_ok_d;
  logic                  line_len_err_q, line_len_err_d, sync_err_q, sync_err_d;
  logic                  vs_rise, vs_fall, vld_fall, line_end;
  logic [15:0]           line_len;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign vs_rise  = vs_q & ~vs_p_q;
  assign vs_fall  = ~vs_q & vs_p_q;
  assign vld_fall = ~vld_q & vld_p_q;

  always_comb begin
    state_d        = state_q;
    vs_d           = vin.vsync;
    hs_d           = vin.hsync;
    vld_d          = vin.valid;
    dat_d          = vin.dat;
    vs_p_d         = vs_q;
    vld_p_d        = vld_q;
    pix_cnt_d      = pix_cnt_q;
    line_cnt_d     = line_cnt_q;
    cur_xres_d     = cur_xres_q;
    len_err_d      = len_err_q;
    syn_err_d      = syn_err_q;
    close_d        = 1'b0;
    pix_valid_d    = vld_q && (state_q == ST_ACTIVE);
    pix_dat_d      = dat_q;
    pix_x_d        = pix_cnt_q;
    pix_y_d        = line_cnt_q;
    meas_xres_d    = meas_xres_q;
    meas_yres_d    = meas_yres_q;
    frame_done_d   = 1'b0;
    frame_cnt_d    = frame_cnt_q;
    res_ok_d       = res_ok_q;
    line_len_err_d = line_len_err_q;
    sync_err_d     = sync_err_q;
    line_end       = 1'b0;
    // a pixel sampled together with the closing vsync still belongs to the open line
    line_len       = vld_q ? sat_inc(pix_cnt_q) : pix_cnt_q;

    case (state_q)
      ST_IDLE: if (vs_fall) state_d = ST_ACTIVE;
      ST_ACTIVE: begin
        if (vld_q) pix_cnt_d = sat_inc(pix_cnt_q);
        if (vld_q && (hs_q || vs_q)) syn_err_d = 1'b1;
        if (vs_rise) begin
          state_d  = ST_SYNC;
          close_d  = 1'b1;
          line_end = vld_p_q || vld_q;
        end else begin
          line_end = vld_fall;
        end
        if (line_end) begin
          pix_cnt_d  = '0;
          line_cnt_d = sat_inc(line_cnt_q);
          if (line_cnt_q == 16'd0) cur_xres_d = line_len;
          else if (line_len != cur_xres_q) len_err_d = 1'b1;
        end
      end
      ST_SYNC: if (vs_fall) state_d = ST_ACTIVE;
      default: state_d = ST_IDLE;
    endcase

    if (close_q) begin
      meas_xres_d    = cur_xres_q;
      meas_yres_d    = line_cnt_q;
      line_len_err_d = len_err_q;
      sync_err_d     = syn_err_q;
      res_ok_d       = (cur_xres_q == 16'(H_DISP)) && (line_cnt_q == 16'(V_DISP))
                       && !len_err_q && !syn_err_q;
      frame_done_d   = 1'b1;
      frame_cnt_d    = frame_cnt_q + 16'd1;
      pix_cnt_d      = '0;
      line_cnt_d     = '0;
      cur_xres_d     = '0;
      len_err_d      = 1'b0;
      syn_err_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      vs_q           <= 1'b0;
      hs_q           <= 1'b0;
      vld_q          <= 1'b0;
      dat_q          <= '0;
      vs_p_q         <= 1'b0;
      vld_p_q        <= 1'b0;
      pix_cnt_q      <= '0;
      line_cnt_q     <= '0;
      cur_xres_q     <= '0;
      len_err_q      <= 1'b0;
      syn_err_q      <= 1'b0;
      close_q        <= 1'b0;
      pix_valid_q    <= 1'b0;
      pix_dat_q      <= '0;
      pix_x_q        <= '0;
      pix_y_q        <= '0;
      meas_xres_q    <= '0;
      meas_yres_q    <= '0;
      frame_done_q   <= 1'b0;
      frame_cnt_q    <= '0;
      res_ok_q       <= 1'b0;
      line_len_err_q <= 1'b0;
      sync_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      vs_q           <= vs_d;
      hs_q           <= hs_d;
      vld_q          <= vld_d;
      dat_q          <= dat_d;
      vs_p_q         <= vs_p_d;
      vld_p_q        <= vld_p_d;
      pix_cnt_q      <= pix_cnt_d;
      line_cnt_q     <= line_cnt_d;
      cur_xres_q     <= cur_xres_d;
      len_err_q      <= len_err_d;
      syn_err_q      <= syn_err_d;
      close_q        <= close_d;
      pix_valid_q    <= pix_valid_d;
      pix_dat_q      <= pix_dat_d;
      pix_x_q        <= pix_x_d;
      pix_y_q        <= pix_y_d;
      meas_xres_q    <= meas_xres_d;
      meas_yres_q    <= meas_yres_d;
      frame_done_q   <= frame_done_d;
      frame_cnt_q    <= frame_cnt_d;
      res_ok_q       <= res_ok_d;
      line_len_err_q <= line_len_err_d;
      sync_err_q     <= sync_err_d;
    end
  end

`ifdef VIDEO_RX_CHECKSUM_EN
  logic [31:0] sum_q, sum_d, frame_sum_q, frame_sum_d;

  always_comb begin
    sum_d       = sum_q;
    frame_sum_d = frame_sum_q;
    if (vld_q && (state_q == ST_ACTIVE)) sum_d = sum_q + 32'(dat_q);
    if (close_q) begin
      frame_sum_d = sum_q;
      sum_d       = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= '0;
      frame_sum_q <= '0;
    end else begin
      sum_q       <= sum_d;
      frame_sum_q <= frame_sum_d;
    end
  end

  assign frame_sum = frame_sum_q;
`else
  assign frame_sum = 32'd0;
`endif

  assign pix_valid    = pix_valid_q;
  assign pix_dat      = pix_dat_q;
  assign pix_x        = pix_x_q;
  assign pix_y        = pix_y_q;
  assign meas_xres    = meas_xres_q;
  assign meas_yres    = meas_yres_q;
  assign frame_done   = frame_done_q;
  assign frame_cnt    = frame_cnt_q;
  assign res_ok       = res_ok_q;
  assign line_len_err = line_len_err_q;
  assign sync_err     = sync_err_q;

endmodule

// File: tb/tb_video_stream_rx_monitor.sv
// Directed bench for video_stream_rx_monitor with 8x4 frames; pixel and frame
// results are predicted into queues and compared when the DUT emits them.
module tb_video_stream_rx_monitor;
  localparam int DW = 8;
  localparam int HD = 8;
  localparam int VD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pix_valid, frame_done, res_ok, line_len_err, sync_err;
  logic [DW-1:0] pix_dat;
  logic [15:0]   pix_x, pix_y, meas_xres, meas_yres, frame_cnt;
  logic [31:0]   frame_sum;

  video_stream_if #(.DATA_WIDTH(DW)) vif ();

  video_stream_rx_monitor #(.DATA_WIDTH(DW), .H_DISP(HD), .V_DISP(VD)) dut (
    .clk(clk), .rst_n(rst_n), .vin(vif),
    .pix_valid(pix_valid), .pix_dat(pix_dat), .pix_x(pix_x), .pix_y(pix_y),
    .meas_xres(meas_xres), .meas_yres(meas_yres), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .res_ok(res_ok), .line_len_err(line_len_err),
    .sync_err(sync_err), .frame_sum(frame_sum)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] x; logic [15:0] y; logic [DW-1:0] d; } pix_t;
  typedef struct {
    logic [15:0] xres; logic [15:0] yres; logic ok; logic lerr; logic serr;
    logic [15:0] fcnt; logic [31:0] sum;
  } frm_t;

  pix_t pq[$];
  frm_t fq[$];

  int          n_cmp = 0;
  int          n_bad = 0;
  bit          in_active = 0;
  int          exp_frames = 0;
  int          f_lines = 0;
  int          f_xres = 0;
  bit          f_lerr = 0;
  bit          f_serr = 0;
  logic [31:0] f_sum = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic vs, input logic hs, input logic vld, input logic [DW-1:0] d);
    @(negedge clk);
    vif.vsync = vs;
    vif.hsync = hs;
    vif.valid = vld;
    vif.dat   = d;
  endtask

  task automatic send_line(input int len, input bit ovl, input bit use_fixed, input logic [DW-1:0] fixed);
    logic [DW-1:0] d;
    repeat (2) step(1'b0, 1'b1, 1'b0, '0);
    if (!ovl) step(1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < len; i++) begin
      d = use_fixed ? fixed : DW'($urandom);
      step(1'b0, ovl && (i == 0), 1'b1, d);
      if (in_active) begin
        pq.push_back('{x: 16'(i), y: 16'(f_lines), d: d});
        f_sum = f_sum + 32'(d);
      end
    end
    repeat (2) step(1'b0, 1'b0, 1'b0, '0);
    if (in_active) begin
      if (f_lines == 0) f_xres = len;
      else if (len != f_xres) f_lerr = 1;
      if (ovl) f_serr = 1;
      f_lines++;
    end
  endtask

  task automatic vsync_pulse();
    frm_t f;
    if (in_active) begin
      exp_frames++;
      f.xres = 16'(f_xres);
      f.yres = 16'(f_lines);
      f.ok   = (f_xres == HD) && (f_lines == VD) && !f_lerr && !f_serr;
      f.lerr = f_lerr;
      f.serr = f_serr;
      f.fcnt = 16'(exp_frames);
`ifdef VIDEO_RX_CHECKSUM_EN
      f.sum  = f_sum;
`else
      f.sum  = 32'd0;
`endif
      fq.push_back(f);
    end
    f_lines = 0; f_xres = 0; f_lerr = 0; f_serr = 0; f_sum = 0;
    repeat (3) step(1'b1, 1'b0, 1'b0, '0);
    in_active = 1;
    repeat (2) step(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic send_frame(input int l0, input int l1, input int l2, input int l3,
                            input int ovl_line, input bit use_fixed, input logic [DW-1:0] fixed);
    send_line(l0, ovl_line == 0, use_fixed, fixed);
    send_line(l1, ovl_line == 1, use_fixed, fixed);
    send_line(l2, ovl_line == 2, use_fixed, fixed);
    send_line(l3, ovl_line == 3, use_fixed, fixed);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
    chk({tag, "_pix_dat"}, 32'(pix_dat), 32'd0);
    chk({tag, "_pix_x"}, 32'(pix_x), 32'd0);
    chk({tag, "_pix_y"}, 32'(pix_y), 32'd0);
    chk({tag, "_meas_xres"}, 32'(meas_xres), 32'd0);
    chk({tag, "_meas_yres"}, 32'(meas_yres), 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    chk({tag, "_res_ok"}, 32'(res_ok), 32'd0);
    chk({tag, "_line_len_err"}, 32'(line_len_err), 32'd0);
    chk({tag, "_sync_err"}, 32'(sync_err), 32'd0);
    chk({tag, "_frame_sum"}, frame_sum, 32'd0);
  endtask

  always @(negedge clk) begin
    pix_t p;
    frm_t f;
    if (rst_n) begin
      if (pix_valid) begin
        if (pq.size() == 0) chk("pix_unexpected", 32'(pix_valid), 32'd0);
        else begin
          p = pq.pop_front();
          chk("pix_x", 32'(pix_x), 32'(p.x));
          chk("pix_y", 32'(pix_y), 32'(p.y));
          chk("pix_dat", 32'(pix_dat), 32'(p.d));
        end
      end
      if (frame_done) begin
        if (fq.size() == 0) chk("frame_unexpected", 32'(frame_done), 32'd0);
        else begin
          f = fq.pop_front();
          chk("meas_xres", 32'(meas_xres), 32'(f.xres));
          chk("meas_yres", 32'(meas_yres), 32'(f.yres));
          chk("res_ok", 32'(res_ok), 32'(f.ok));
          chk("line_len_err", 32'(line_len_err), 32'(f.lerr));
          chk("sync_err", 32'(sync_err), 32'(f.serr));
          chk("frame_cnt", 32'(frame_cnt), 32'(f.fcnt));
          chk("frame_sum", frame_sum, f.sum);
        end
      end
    end
  end

  initial begin
    vif.vsync = 1'b0;
    vif.hsync = 1'b0;
    vif.valid = 1'b0;
    vif.dat   = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst0");

    // reset released while a frame is already in progress: that frame is ignored
    send_line(HD, 0, 0, '0);
    send_line(HD, 0, 0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    send_line(HD, 0, 0, '0);
    send_line(HD, 0, 0, '0);
    vsync_pulse();
    send_frame(HD, HD, HD, HD, -1, 0, '0);
    vsync_pulse();

    send_frame(HD, HD, HD, HD, -1, 0, '0);
    vsync_pulse();
    send_frame(HD, HD, HD, HD, -1, 0, '0);
    vsync_pulse();

    send_frame(HD, HD, HD - 1, HD, -1, 0, '0);
    vsync_pulse();

    send_frame(HD, HD, HD, HD, 1, 0, '0);
    vsync_pulse();
    send_frame(HD, HD, HD, HD, -1, 0, '0);
    vsync_pulse();

    send_frame(HD, HD, HD, HD, -1, 1, 8'h10);
    vsync_pulse();
    vsync_pulse();

    // reset on line 3 abandons the frame
    send_line(HD, 0, 0, '0);
    send_line(HD, 0, 0, '0);
    repeat (3) step(1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);
    rst_n      = 1'b0;
    in_active  = 0;
    exp_frames = 0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst_mid");
    rst_n = 1'b1;
    vsync_pulse();
    send_frame(HD, HD, HD, HD, -1, 0, '0);
    vsync_pulse();

    repeat (10) @(negedge clk);
    chk("pix_missing", 32'(pq.size()), 32'd0);
    chk("frame_missing", 32'(fq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/video_stream_rx_monitor.md
Name: video_stream_rx_monitor

Overview:
- Synthesizable receive end of the team's video stream interface: vsync / hsync / valid / data.
- Sits downstream of any image-processing stage (for example the average filter).
- Recovers pixel coordinates and measures frame resolution from the stream itself.
- Flags timing and protocol errors, and reports per-frame results with a one-cycle frame_done pulse.
- Serves as the hardware counterpart of the bench frame-capture model, for on-chip self-check.

Parameters:
- DATA_WIDTH, 8, pixel data width.
- H_DISP, 800, expected active pixels per line.
- V_DISP, 600, expected active lines per frame.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- vin_vsync  in  1  frame sync; high during the sync pulse.
- vin_hsync  in  1  line sync; high during the sync pulse.
- vin_valid  in  1  active pixel qualifier.
- vin_dat  in  DATA_WIDTH  pixel data.
- pix_valid  out  1  registered copy of vin_valid, gated to the ACTIVE state.
- pix_dat  out  DATA_WIDTH  registered pixel data.
- pix_x  out  16  column of pix_dat, starting at 0.
- pix_y  out  16  row of pix_dat, starting at 0.
- meas_xres  out  16  length of the first line of the last completed frame.
- meas_yres  out  16  line count of the last completed frame.
- frame_done  out  1  one-cycle pulse when a frame's results are latched.
- frame_cnt  out  16  number of completed frames; wraps at 16'hFFFF.
- res_ok  out  1  last frame matched H_DISP x V_DISP with no errors.
- line_len_err  out  1  last frame had unequal line lengths.
- sync_err  out  1  last frame had vin_valid high while vin_hsync or vin_vsync was high.
- frame_sum  out  32  pixel checksum of the last frame (see Optional Feature).

Behaviour:
- Reset: every output is 0 and the FSM is in IDLE. Reset is legal at any time; it abandons the current frame and no frame_done is issued for it.
- Inputs are registered once. Edge detection compares the registered sample against the previous registered sample.
- FSM states:
  - IDLE → ACTIVE on a vsync falling edge. A partial frame seen after reset is ignored.
  - ACTIVE → SYNC on a vsync rising edge, which closes the frame.
  - SYNC → ACTIVE on a vsync falling edge.
- Pixel counting in ACTIVE:
  - pix_cnt increments on each registered valid.
  - A falling edge of valid ends a line: line_cnt increments and pix_cnt clears.
- Line length checking:
  - The first line's length is stored as cur_xres.
  - Any later line whose length differs from cur_xres sets the internal line-length error flag for the frame.
- sync_err condition: valid and (hsync or vsync) sampled together in ACTIVE sets the internal sync error flag.
- Frame close (vsync rising edge while in ACTIVE):
  - If valid was high on the previous sample, the open line is counted and length-checked first.
  - On the next clock: meas_xres = cur_xres and meas_yres = line_cnt.
  - line_len_err and sync_err are loaded from the internal flags.
  - res_ok = (cur_xres == H_DISP) && (line_cnt == V_DISP) && !errors.
  - frame_done pulses for exactly 1 cycle and frame_cnt increments.
  - Internal counters and flags clear.
- A zero-line frame (no valid between vsyncs) still pulses frame_done with meas_xres = 0, meas_yres = 0, res_ok = 0.
- Outputs other than frame_done hold until the next frame_done.
- Pixel path:
  - Latency is 2 cycles from vin_* to pix_*.
  - pix_x = pix_cnt and pix_y = line_cnt at capture.
  - pix_valid is 0 outside ACTIVE.
- All counters saturate at 16'hFFFF, except frame_cnt, which wraps.
- Simultaneous vsync rise and valid fall in one sample: the line is closed first, then the frame.

Optional Feature:
- Macro: VIDEO_RX_CHECKSUM_EN.
- Defined: a 32-bit accumulator adds zero-extended vin_dat for every valid pixel in ACTIVE, modulo 2^32. It is latched into frame_sum at frame_done and cleared afterwards.
- Undefined: no accumulator is built and frame_sum is tied to 0.

Test Plan:
All cases use H_DISP = 8, V_DISP = 4 unless stated.
1. Clean 8x4 frame with 2 vsync periods → frame_done exactly once per frame; meas_xres = 8, meas_yres = 4, res_ok = 1, frame_cnt = 1 then 2; pix_x/pix_y run 0..7 / 0..3 at 2-cycle latency.
2. Release reset mid-frame (line 2 of 4) → no frame_done for that partial frame; first frame_done follows the next full frame with meas_yres = 4.
3. Line lengths 8, 8, 7, 8 → line_len_err = 1, res_ok = 0, meas_xres = 8, meas_yres = 4.
4. vin_valid held high one cycle during an hsync pulse → sync_err = 1, res_ok = 0; the next clean frame clears both.
5. With VIDEO_RX_CHECKSUM_EN and all pixels 0x10 in an 8x4 frame → frame_sum = 0x00000200. Without the macro → frame_sum = 0.
6. Assert rst_n low on line 3, then release and send a clean frame → all outputs 0 during reset; next frame_done reports 8x4, res_ok = 1, frame_cnt = 1.
